// File: rtl/tcdm_rr_arbiter_if.sv
// TCDM port bundle: request channel (req/add/wen/be/data), grant, and response channel (r_data/r_valid).
interface hwpe_stream_intf_tcdm;
  logic        req;
  logic        gnt;
  logic [31:0] add;
  logic        wen;
  logic [3:0]  be;
  logic [31:0] data;
  logic [31:0] r_data;
  logic        r_valid;

  modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
  modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

// File: rtl/tcdm_rr_arbiter.sv
// Round-robin arbiter sharing one TCDM slave among NB_IN masters; an in-order ID FIFO
// steers each downstream response back to the master that issued the request.
module tcdm_rr_arbiter #(
  parameter int unsigned NB_IN           = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               enable_i,
  hwpe_stream_intf_tcdm.slave                in_tcdm [NB_IN-1:0],
  hwpe_stream_intf_tcdm.master               out_tcdm,
  output logic                               err_o,
  output logic [$clog2(MAX_OUTSTANDING):0]   outstanding_o
);
  localparam int unsigned IW    = $clog2(NB_IN);
  localparam int unsigned PW    = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CW    = $clog2(MAX_OUTSTANDING) + 1;
  localparam int unsigned DEPTH = 2 ** PW;

  logic [NB_IN-1:0] req_v, gnt_v, rvalid_v, wen_a;
  logic [31:0]      add_a  [NB_IN];
  logic [31:0]      data_a [NB_IN];
  logic [3:0]       be_a   [NB_IN];

  for (genvar k = 0; k < NB_IN; k++) begin : g_port
    assign req_v[k]              = in_tcdm[k].req;
    assign add_a[k]              = in_tcdm[k].add;
    assign wen_a[k]              = in_tcdm[k].wen;
    assign be_a[k]               = in_tcdm[k].be;
    assign data_a[k]             = in_tcdm[k].data;
    assign in_tcdm[k].gnt        = gnt_v[k];
    assign in_tcdm[k].r_valid    = rvalid_v[k];
    assign in_tcdm[k].r_data     = out_tcdm.r_data;
  end

  logic [IW-1:0] ptr_q, ptr_d, win;
  logic          win_vld, issue_ok, fwd, push, pop, empty;
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [IW-1:0] id_q [DEPTH];

  // First requester at or after ptr_q, wrapping modulo NB_IN.
  always_comb begin
    logic [IW-1:0] idx;
    win     = '0;
    win_vld = 1'b0;
    idx     = '0;
    for (int unsigned i = 0; i < NB_IN; i++) begin
      idx = IW'((32'(ptr_q) + i) % NB_IN);
      if (!win_vld && req_v[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  assign empty    = (cnt_q == '0);
  assign issue_ok = enable_i & (cnt_q < CW'(MAX_OUTSTANDING));
  assign fwd      = issue_ok & win_vld;
  assign push     = fwd & out_tcdm.gnt;
  // A response with the FIFO empty is never a match, even if a push lands in the same cycle.
  assign pop      = out_tcdm.r_valid & ~empty;

  assign out_tcdm.req  = fwd;
  assign out_tcdm.add  = fwd ? add_a[win]  : '0;
  assign out_tcdm.wen  = fwd ? wen_a[win]  : 1'b0;
  assign out_tcdm.be   = fwd ? be_a[win]   : '0;
  assign out_tcdm.data = fwd ? data_a[win] : '0;

  always_comb begin
    gnt_v    = '0;
    rvalid_v = '0;
    if (fwd) gnt_v[win] = out_tcdm.gnt;
    if (pop) rvalid_v[id_q[rd_q]] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (push) ptr_d = (win == IW'(NB_IN - 1)) ? '0 : win + IW'(1);
    wr_d  = push ? wr_q + PW'(1) : wr_q;
    rd_d  = pop  ? rd_q + PW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    err_d = err_q | (out_tcdm.r_valid & empty);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) id_q[wr_q] <= win;
  end

  assign err_o         = err_q;
  assign outstanding_o = cnt_q;
endmodule

// File: tb/tb_tcdm_rr_arbiter.sv
// Directed bench for tcdm_rr_arbiter: memory model on the shared port, grant and response
// scoreboards fed by the stimulus and drained by independent monitors.
module tb_tcdm_rr_arbiter;
  localparam int unsigned NB = 4;
  localparam int unsigned MO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic err;
  logic [2:0] occ;
  always #5 clk = ~clk;

  hwpe_stream_intf_tcdm in_if [NB-1:0] ();
  hwpe_stream_intf_tcdm out_if ();

  tcdm_rr_arbiter #(.NB_IN(NB), .MAX_OUTSTANDING(MO)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en),
    .in_tcdm(in_if), .out_tcdm(out_if),
    .err_o(err), .outstanding_o(occ)
  );

  logic [NB-1:0] req_s = '0, wen_s = '0, gnt_m, rv_m;
  logic [31:0]   add_s [NB];
  logic [31:0]   data_s[NB];
  logic [3:0]    be_s  [NB];
  logic [31:0]   rd_m  [NB];

  for (genvar g = 0; g < NB; g++) begin : g_drv
    assign in_if[g].req  = req_s[g];
    assign in_if[g].add  = add_s[g];
    assign in_if[g].wen  = wen_s[g];
    assign in_if[g].be   = be_s[g];
    assign in_if[g].data = data_s[g];
    assign gnt_m[g]      = in_if[g].gnt;
    assign rv_m[g]       = in_if[g].r_valid;
    assign rd_m[g]       = in_if[g].r_data;
  end

  typedef struct packed { logic [31:0] port; logic [31:0] data; } rsp_t;
  rsp_t        exp_rsp[$];
  int unsigned exp_gnt[$];
  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;
  int unsigned max_occ = 0;
  logic [2:0]  occ_at_gnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic void exp_r(input int unsigned p, input logic [31:0] d);
    rsp_t r;
    r.port = p;
    r.data = d;
    exp_rsp.push_back(r);
  endfunction

  // ---------------- memory model on the shared port (1-cycle latency) ----------------
  logic [31:0] mem [int unsigned];
  logic [31:0] mq[$];
  bit hold = 1'b0, stray_req = 1'b0, cur_stray = 1'b0;

  initial begin : memory
    bit hs, cons, w;
    logic [31:0] a, d, old;
    logic [3:0] b;
    out_if.gnt = 1'b1;
    out_if.r_valid = 1'b0;
    out_if.r_data = '0;
    forever begin
      @(negedge clk);
      hs   = out_if.req & out_if.gnt;
      a    = out_if.add;
      w    = out_if.wen;
      b    = out_if.be;
      d    = out_if.data;
      cons = out_if.r_valid && !cur_stray;
      @(posedge clk); #1;
      if (cons && mq.size() > 0) void'(mq.pop_front());
      if (hs) begin
        old = mem.exists(a) ? mem[a] : {16'hC0DE, a[15:0]};
        if (w) mq.push_back(old);
        else begin
          for (int i = 0; i < 4; i++) if (b[i]) old[8*i +: 8] = d[8*i +: 8];
          mem[a] = old;
          mq.push_back('0);
        end
      end
      if (stray_req) begin
        out_if.r_valid = 1'b1;
        out_if.r_data  = 32'hBAD0BAD0;
        cur_stray = 1'b1;
        stray_req = 1'b0;
      end else begin
        cur_stray = 1'b0;
        out_if.r_valid = !hold && (mq.size() > 0);
        out_if.r_data  = (mq.size() > 0) ? mq[0] : '0;
      end
    end
  end

  // ---------------- monitors ----------------
  initial begin : gnt_mon
    forever begin
      @(negedge clk);
      for (int k = 0; k < NB; k++) if (gnt_m[k]) begin
        if (exp_gnt.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_gnt: port %0d granted, none expected (cycle %0d)", k, cyc);
        end else check("gnt_port", k, exp_gnt.pop_front());
      end
    end
  end

  initial begin : rsp_mon
    rsp_t e;
    forever begin
      @(negedge clk);
      if (occ > max_occ) max_occ = occ;
      for (int k = 0; k < NB; k++) if (rv_m[k]) begin
        if (exp_rsp.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rvalid: port %0d data %h, none expected (cycle %0d)", k, rd_m[k], cyc);
        end else begin
          e = exp_rsp.pop_front();
          check("rsp_port", k, e.port);
          check("rsp_data", rd_m[k], e.data);
        end
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+#1) ----------------
  task automatic set_port(input int k, input logic [31:0] a, input logic w,
                          input logic [3:0] b, input logic [31:0] d);
    add_s[k] = a; wen_s[k] = w; be_s[k] = b; data_s[k] = d; req_s[k] = 1'b1;
  endtask

  task automatic wait_any_gnt(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|gnt_m) begin ok = 1'b1; occ_at_gnt = occ; break; end
    end
    check({name, "_gnt_seen"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_req(input int k, input logic [31:0] a, input logic w,
                        input logic [3:0] b, input logic [31:0] d);
    set_port(k, a, w, b, d);
    wait_any_gnt("do_req");
    req_s[k] = 1'b0;
  endtask

  task automatic drain(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (exp_rsp.size() == 0 && mq.size() == 0 && !out_if.r_valid) begin ok = 1'b1; break; end
    end
    check({name, "_drained"}, 32'(ok), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    req_s = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main
    int unsigned t0;
    for (int k = 0; k < NB; k++) begin
      add_s[k] = '0; data_s[k] = '0; be_s[k] = '0;
    end
    mem[32'h20] = 32'h11223344;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset state
    @(negedge clk);
    check("rst_occ", 32'(occ), 0);
    check("rst_err", 32'(err), 0);
    check("rst_out_req", 32'(out_if.req), 0);
    check("rst_gnt", 32'(gnt_m), 0);
    check("rst_rvalid", 32'(rv_m), 0);
    @(posedge clk); #1;

    // single requester, back-to-back reads
    repeat (3) exp_gnt.push_back(2);
    exp_r(2, 32'hC0DE0010); exp_r(2, 32'hC0DE0014); exp_r(2, 32'hC0DE0018);
    max_occ = 0;
    t0 = cyc;
    do_req(2, 32'h10, 1'b1, 4'hF, '0);
    do_req(2, 32'h14, 1'b1, 4'hF, '0);
    do_req(2, 32'h18, 1'b1, 4'hF, '0);
    check("single_cycles", cyc - t0, 3);
    drain("single");
    check("single_max_occ", max_occ, 1);
    check("single_err", 32'(err), 0);

    // fairness from reset
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NB; k++) begin
        exp_gnt.push_back(k);
        exp_r(k, 32'hC0DE0100 + 32'(4 * k));
      end
    for (int k = 0; k < NB; k++) set_port(k, 32'h100 + 32'(4 * k), 1'b1, 4'hF, '0);
    repeat (8) @(posedge clk);
    #1;
    req_s = '0;
    check("fair_gnt_left", exp_gnt.size(), 0);
    drain("fair");

    // backpressure: ptr is 0 after last winner 3
    @(negedge clk); hold = 1'b1;
    @(posedge clk); #1;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0);
    for (int r = 0; r < 2; r++) begin exp_r(0, 32'hC0DE0200); exp_r(1, 32'hC0DE0204); end
    exp_r(0, 32'hC0DE0200);
    set_port(0, 32'h200, 1'b1, 4'hF, '0);
    set_port(1, 32'h204, 1'b1, 4'hF, '0);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_occ_full", 32'(occ), 4);
    check("bp_out_req", 32'(out_if.req), 0);
    check("bp_gnt_left", exp_gnt.size(), 1);
    hold = 1'b0;
    @(posedge clk); #1;
    wait_any_gnt("bp_regrant");
    req_s = '0;
    check("bp_occ_at_regrant", 32'(occ_at_gnt), 3);
    drain("bp");

    // write then read of the same word
    exp_gnt.push_back(1); exp_gnt.push_back(3);
    exp_r(1, 32'h0); exp_r(3, 32'h1122BEEF);
    do_req(1, 32'h20, 1'b0, 4'b0011, 32'hDEADBEEF);
    do_req(3, 32'h20, 1'b1, 4'hF, '0);
    drain("wr_rd");

    // stray response with empty FIFO
    @(negedge clk); stray_req = 1'b1;
    @(negedge clk);
    check("stray_rvalid", 32'(rv_m), 0);
    check("stray_err_same_cycle", 32'(err), 0);
    @(negedge clk);
    check("stray_err_set", 32'(err), 1);
    repeat (3) @(negedge clk);
    check("stray_err_sticky", 32'(err), 1);
    @(posedge clk); #1;

    // reset with three transactions in flight
    @(negedge clk); hold = 1'b1;
    @(posedge clk); #1;
    exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(2);
    for (int k = 0; k < 3; k++) set_port(k, 32'h300 + 32'(4 * k), 1'b1, 4'hF, '0);
    repeat (3) @(posedge clk);
    #1;
    req_s = '0;
    @(negedge clk);
    check("mid_occ_before", 32'(occ), 3);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("mid_occ_after", 32'(occ), 0);
    check("mid_err_after", 32'(err), 0);
    hold = 1'b0;
    @(posedge clk); #1;
    drain("late");
    check("late_err", 32'(err), 1);

    // enable gating; first grant after reset must go to port 0
    exp_gnt.push_back(0); exp_gnt.push_back(1);
    exp_r(0, 32'hC0DE0300); exp_r(1, 32'hC0DE0304);
    for (int k = 0; k < NB; k++) set_port(k, 32'h300 + 32'(4 * k), 1'b1, 4'hF, '0);
    wait_any_gnt("en_first");
    req_s[0] = 1'b0;
    en = 1'b0;
    @(negedge clk);
    check("en_off_rsp_routed", 32'(rv_m), 32'b0001);
    for (int i = 0; i < 3; i++) begin
      check("en_off_out_req", 32'(out_if.req), 0);
      check("en_off_gnt", 32'(gnt_m), 0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    en = 1'b1;
    wait_any_gnt("en_on");
    req_s = '0;
    drain("en");

    check("final_gnt_queue", exp_gnt.size(), 0);
    check("final_rsp_queue", exp_rsp.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
